// File: rtl/mbc1_cart.sv
// mbc1_cart: MBC1 bank controller between the Game Boy CPU bus and cartridge ROM/SRAM.
// CPU writes to 0000-7FFF program the control registers; reads are mapped through
// the current ROM/RAM banks and returned on Di one clock later.
// Optional build macro: MBC1_MULTICART_EN (4-bit bank_lo, 6-bit ROM bank).
module mbc1_cart #(
    parameter int ROM_BANKS = 128,
    parameter int RAM_BANKS = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] A,
    input  logic [7:0]  Do,
    output logic [7:0]  Di,
    input  logic        wr_n,
    input  logic        rd_n,
    input  logic        cs_n,
    output logic [20:0] rom_addr,
    input  logic [7:0]  rom_rdata,
    output logic [14:0] ram_addr,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  ram_wdata,
    output logic        ram_we
);

`ifdef MBC1_MULTICART_EN
    localparam int LO_W = 4;
`else
    localparam int LO_W = 5;
`endif

    localparam logic [6:0] ROM_MASK = 7'(ROM_BANKS - 1);

    logic [LO_W-1:0] bank_lo_r;
    logic [1:0]      bank_hi_r;
    logic            ram_en_r;
    logic            mode_r;
    logic            wr_q_r;
    logic            wr_arm_r;   // set once wr_n has been seen high since reset

    logic            wr_fire_s;
    logic            ram_sel_s;
    logic            ctrl_wr_s;
    logic [6:0]      rom_bank_s;
    logic [1:0]      ram_bank_s;

    // A strobe held low across reset release must not fire, hence the arm flag.
    assign wr_fire_s = wr_arm_r & wr_q_r & ~wr_n;
    assign ram_sel_s = ~cs_n & (A[15:13] == 3'b101);
    assign ctrl_wr_s = wr_fire_s & ~A[15];

    assign ram_wdata = Do;
    assign ram_we    = wr_fire_s & ram_sel_s & ram_en_r;
    assign ram_addr  = {ram_bank_s, A[12:0]};
    assign rom_addr  = {rom_bank_s & ROM_MASK, A[13:0]};

    // Select the ROM bank: fixed low window (optionally high-banked in mode 1) or switchable window.
    always_comb begin
        rom_bank_s = 7'd0;
        if (A[14] == 1'b0) begin
            if (mode_r) begin
                rom_bank_s = 7'({bank_hi_r, {LO_W{1'b0}}});
            end else begin
                rom_bank_s = 7'd0;
            end
        end else begin
            rom_bank_s = 7'({bank_hi_r, bank_lo_r});
        end
    end

    // Select the RAM bank; only a 4-bank cart in mode 1 uses bank_hi.
    always_comb begin
        ram_bank_s = 2'd0;
        if (mode_r && (RAM_BANKS == 4)) begin
            ram_bank_s = bank_hi_r;
        end else begin
            ram_bank_s = 2'd0;
        end
    end

    // Write-strobe edge detector and arming after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_q_r   <= 1'b1;
            wr_arm_r <= 1'b0;
        end else begin
            wr_q_r <= wr_n;
            if (wr_n) begin
                wr_arm_r <= 1'b1;
            end
        end
    end

    // MBC control registers, written by one commit per low write strobe to 0000-7FFF.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ram_en_r  <= 1'b0;
            bank_lo_r <= {{(LO_W-1){1'b0}}, 1'b1};
            bank_hi_r <= 2'd0;
            mode_r    <= 1'b0;
        end else if (ctrl_wr_s) begin
            case (A[14:13])
                2'b00: ram_en_r <= (Do[3:0] == 4'hA);
                2'b01: begin
                    if (Do[LO_W-1:0] == {LO_W{1'b0}}) begin
                        bank_lo_r <= {{(LO_W-1){1'b0}}, 1'b1};
                    end else begin
                        bank_lo_r <= Do[LO_W-1:0];
                    end
                end
                2'b10: bank_hi_r <= Do[1:0];
                2'b11: mode_r    <= Do[0];
                default: mode_r  <= mode_r;
            endcase
        end
    end

    // Registered read data: ROM, enabled RAM, or open bus (FF).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Di <= 8'hFF;
        end else if (!rd_n && !A[15]) begin
            Di <= rom_rdata;
        end else if (!rd_n && ram_sel_s) begin
            Di <= ram_en_r ? ram_rdata : 8'hFF;
        end else begin
            Di <= 8'hFF;
        end
    end

endmodule
